// File: rtl/cache_def.sv
// Shared definitions for the risk cache block: arbiter state encoding and the
// field boundaries of the packed max-to-trade / accumulated-amount data word.
package cache_def;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int unsigned RISK_MAX_MSB = 31;
  localparam int unsigned RISK_ACC_MSB = 15;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin one-hot picker: the winner is the first set bit of
// req scanning upward from ptr+1, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic        found;
    int unsigned cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // ptr itself is scanned last, so the previous winner has lowest priority.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!found && req[cand[IW-1:0]]) begin
        found              = 1'b1;
        idx                = cand[IW-1:0];
        gnt[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/risk_cache_arbiter.sv
// Round-robin arbiter that shares the single CPU port of the risk cache among
// NREQ order-entry requesters, with a per-transaction watchdog.
module risk_cache_arbiter
  import cache_def::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDXW    = 14,
  parameter int unsigned DATAW   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_rw,
  input  logic [NREQ*IDXW-1:0]  req_index,
  input  logic [NREQ*DATAW-1:0] req_data,
  output logic [NREQ-1:0]       req_gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [DATAW-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  cpu_valid,
  output logic                  cpu_rw,
  output logic [IDXW-1:0]       cpu_index,
  output logic [DATAW-1:0]      cpu_data,
  input  logic                  cpu_ready,
  input  logic [DATAW-1:0]      cpu_rdata,
  output logic                  timeout_flag,
  output logic [15:0]           txn_count
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT) + 1;
  localparam logic [PW-1:0] PtrRst  = PW'(NREQ - 1);
  localparam logic [WW-1:0] WdogMax = WW'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic             rw_q, rw_d;
  logic [IDXW-1:0]  index_q, index_d;
  logic [DATAW-1:0] data_q, data_d;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATAW-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      txn_q, txn_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [PW-1:0]    pick_idx;

  rr_pick #(
    .N  (NREQ),
    .IW (PW)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    rw_d        = rw_q;
    index_d     = index_q;
    data_d      = data_q;
    wdog_d      = wdog_q;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    timeout_d   = timeout_q;
    txn_d       = txn_q;
    req_gnt     = '0;

    unique case (state_q)
      IDLE: begin
        // Grant is combinational but must read as 0 while reset is held.
        req_gnt = rst ? '0 : pick_gnt;
        if (|pick_gnt) begin
          state_d = BUSY;
          win_d   = pick_idx;
          rw_d    = req_rw[pick_idx];
          index_d = req_index[32'(pick_idx) * IDXW +: IDXW];
          data_d  = req_data[32'(pick_idx) * DATAW +: DATAW];
          wdog_d  = '0;
        end
      end
      BUSY: begin
        // Completion takes priority over a watchdog expiry on the same edge.
        if (cpu_ready) begin
          state_d            = IDLE;
          rsp_valid_d[win_q] = 1'b1;
          rsp_data_d         = cpu_rdata;
          ptr_d              = win_q;
          txn_d              = txn_q + 16'd1;
        end else if (wdog_q == WdogMax) begin
          state_d            = IDLE;
          rsp_valid_d[win_q] = 1'b1;
          rsp_err_d          = 1'b1;
          timeout_d          = 1'b1;
          ptr_d              = win_q;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= PtrRst;
      win_q       <= '0;
      rw_q        <= 1'b0;
      index_q     <= '0;
      data_q      <= '0;
      wdog_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      txn_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      rw_q        <= rw_d;
      index_q     <= index_d;
      data_q      <= data_d;
      wdog_q      <= wdog_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
      txn_q       <= txn_d;
    end
  end

  assign cpu_valid    = (state_q == BUSY);
  assign cpu_rw       = rw_q;
  assign cpu_index    = index_q;
  assign cpu_data     = data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign timeout_flag = timeout_q;
  assign txn_count    = txn_q;

endmodule

// File: doc/risk_cache_arbiter.md
# risk_cache_arbiter

Round-robin arbiter and sequencer that shares the single CPU-side port of the upstream risk cache FSM among `NREQ` order-entry requesters. Each request is a client-indexed read, or a write of max-to-trade / accumulated-order data. The block latches one request, holds it stable on the cache port until the cache answers, and routes the result back to the winner. A watchdog bounds every transaction.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `IDXW`, 14: client index width; matches `rdindex`.
- `DATAW`, 32: data word width; [31:16] is max-to-trade, [15:0] is accumulated amount.
- `TIMEOUT`, 64: maximum cycles in BUSY before abort.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_rw`  in  NREQ  1 = write.
- `req_index`  in  NREQ*IDXW  client index; requester i is at [i*IDXW +: IDXW].
- `req_data`  in  NREQ*DATAW  write data, packed the same way.
- `req_gnt`  out  NREQ  one-hot request accept.
- `rsp_valid`  out  NREQ  one-hot, one-cycle response strobe.
- `rsp_data`  out  DATAW  read data; valid with `rsp_valid`.
- `rsp_err`  out  1  response is a timeout abort; valid with `rsp_valid`.
- `cpu_valid`, `cpu_rw`, `cpu_index`, `cpu_data`  out  1/1/IDXW/DATAW  drive the cache `cpu_req`.
- `cpu_ready`  in  1  cache `cpu_res.ready`.
- `cpu_rdata`  in  DATAW  cache `cpu_res.data`.
- `timeout_flag`  out  1  sticky; set on any abort; cleared only by `rst`.
- `txn_count`  out  16  completed transactions, wraps at 0xFFFF -> 0; aborts are not counted.

## Operation
- States:
  - IDLE: `req_gnt` is combinational. The winner is the first set `req_valid` scanning from `ptr+1` modulo NREQ.
  - IDLE -> BUSY: on a clock edge where any `req_gnt` bit is high. At that edge, latch rw/index/data/winner into registers and reset the watchdog to 0.
  - BUSY: `cpu_valid` = 1. `cpu_*` fields come from the latched registers and stay constant throughout BUSY.
  - BUSY -> IDLE on an edge with `cpu_ready` = 1. Actions at that edge:
    - register `rsp_valid[winner]` = 1 and `rsp_data` = `cpu_rdata`, with `rsp_err` = 0;
    - set `ptr` <= winner;
    - increment `txn_count`.
  - BUSY -> IDLE on watchdog expiry (counter == TIMEOUT-1 with no `cpu_ready`). Actions at that edge:
    - register `rsp_valid[winner]` = 1, `rsp_err` = 1, `rsp_data` = 0;
    - set `timeout_flag`;
    - set `ptr` <= winner.
- Write handling: the arbiter does not interpret data. The cache decides max-update vs accumulate.
- Requesters hold `req_valid`/`req_*` stable until they see `req_gnt`. The arbiter never grants while in BUSY.
- A requester may present its next request while its own response is pending; it is granted only after the pending response is returned.

## Timing
- Reset values:
  - outputs: `req_gnt` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0, `cpu_valid` 0, `cpu_*` 0, `timeout_flag` 0, `txn_count` 0;
  - internal: `ptr` = NREQ-1 (requester 0 has first priority), state IDLE.
- Grant edge T, so `cpu_valid` = 1 from T+1. If `cpu_ready` is seen at edge T+k, then `rsp_valid` is high for cycle T+k+1 and `cpu_valid` = 0 in that same cycle.
- The IDLE cycle after every transaction guarantees `cpu_valid` low for at least one cycle, so the cache FSM returns to idle before the next request.
- Back-to-back throughput: one transaction per (cache latency + 2) cycles.
- `cpu_ready` while in IDLE is ignored.
- `cpu_ready` on the same edge as watchdog expiry counts as completion, not abort.
- `rst` mid-BUSY: the transaction is dropped, no `rsp_valid` is issued, and `cpu_valid` is 0 the next cycle.

## Structure
- Shared `cache_def` package additions:
  - `arb_state_t` enum {IDLE, BUSY};
  - localparam `RISK_MAX_MSB` = 31 and `RISK_ACC_MSB` = 15.
- Sub-module `rr_pick`: combinational round-robin one-hot picker with inputs `req`, `ptr` and outputs `gnt`, `idx`. Reused by later schedulers.

## Test plan
- Single read: `req_valid[2]` = 1, index 0x0050; cache asserts ready 3 cycles after `cpu_valid`. Expected:
  - `req_gnt` = 4'b0100;
  - `rsp_valid[2]` pulses with `rsp_data` = `cpu_rdata`;
  - `txn_count` = 1.
- All four requesting continuously after reset: grant order is 0,1,2,3,0, and `cpu_valid` is low for exactly one cycle between transactions.
- Write 0x00050003 by requester 1: `cpu_rw` = 1 and `cpu_data` = 0x00050003, both stable every BUSY cycle. Changing `req_data[1]` during BUSY does not change `cpu_data`.
- Cache never readies: after 64 BUSY cycles, `rsp_valid` = 1 with `rsp_err` = 1; `timeout_flag` stays 1; `txn_count` is unchanged.
- `cpu_ready` on the expiry edge: `rsp_err` = 0 and `timeout_flag` = 0.
- `rst` asserted 2 cycles into BUSY: no `rsp_valid` is issued, `cpu_valid` = 0 next cycle, and after release requester 0 wins first.
